// File: rtl/rv_acc_pkg.sv
// rv_acc_pkg: shared Q(IW).(FW) formats, accumulator width, saturation bounds and FSM states
package rv_acc_pkg;
  localparam int IW = 24;
  localparam int FW = 8;
  localparam int DW = IW + FW;
  localparam int GW = 6;
  localparam int AW = DW + GW;
  typedef logic signed [DW-1:0] fx_t;
  typedef logic signed [AW-1:0] acc_t;
  localparam fx_t SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam fx_t SAT_MIN = {1'b1, {(DW-1){1'b0}}};
  typedef enum logic {IDLE, ACC} state_t;
endpackage

// File: rtl/psum_sat_relu.sv
// psum_sat_relu: one lane of bias add, optional ReLU and saturation to DW bits
//   sum     in  AW-bit accumulated partial sum
//   bias    in  DW-bit signed bias
//   relu_en in  clamp negative results to zero
//   res     out DW-bit saturated result
module psum_sat_relu
  import rv_acc_pkg::*;
(
  input  acc_t sum,
  input  fx_t  bias,
  input  logic relu_en,
  output fx_t  res
);
  acc_t r, c;
  always_comb begin
    r = sum + acc_t'(bias);
    c = (relu_en && r[AW-1]) ? '0 : r;
    res = (c > acc_t'(SAT_MAX)) ? SAT_MAX : (c < acc_t'(SAT_MIN)) ? SAT_MIN : c[DW-1:0];
  end
endmodule

// File: rtl/psum_accum.sv
// psum_accum: accumulates pe3x3 partial-sum beats per group, adds bias, ReLU/saturates, valid/ready output
//   clk, rst_n            clock, synchronous active-low reset
//   psum_i/valid/last     input beat, OUTPUT_NUM signed DW-bit lanes
//   psum_ready_o          beat can be accepted (output slot free or draining)
//   bias_i, relu_en_i     sampled on the accepted last beat
//   res_o/valid/ready     result slot handshake
//   err_o                 sticky: a group ran past MAX_ACC beats
module psum_accum
  import rv_acc_pkg::*;
#(
  parameter int OUTPUT_NUM = 9,
  parameter int MAX_ACC    = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [OUTPUT_NUM*DW-1:0]   psum_i,
  input  logic                       psum_valid_i,
  input  logic                       psum_last_i,
  output logic                       psum_ready_o,
  input  logic [DW-1:0]              bias_i,
  input  logic                       relu_en_i,
  output logic [OUTPUT_NUM*DW-1:0]   res_o,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic                       err_o
);
  localparam int CW = $clog2(MAX_ACC + 1);
  state_t state, state_n;
  logic [CW-1:0] beat_cnt;
  acc_t acc [OUTPUT_NUM];
  acc_t sum [OUTPUT_NUM];
  logic [OUTPUT_NUM*DW-1:0] res_n;
  logic accept;
  assign psum_ready_o = ~res_valid_o | res_ready_i;
  assign accept = psum_valid_i & psum_ready_o;
  always_comb state_n = accept ? (psum_last_i ? IDLE : ACC) : state;
  for (genvar k = 0; k < OUTPUT_NUM; k++) begin : g_lane
    fx_t p;
    assign p = psum_i[k*DW +: DW];
    // the first beat of a group starts from zero rather than the stored accumulator
    assign sum[k] = ((state == IDLE) ? '0 : acc[k]) + acc_t'(p);
    psum_sat_relu u_sat (
      .sum    (sum[k]),
      .bias   (bias_i),
      .relu_en(relu_en_i),
      .res    (res_n[k*DW +: DW])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      res_o       <= '0;
      res_valid_o <= 1'b0;
      err_o       <= 1'b0;
      for (int i = 0; i < OUTPUT_NUM; i++) acc[i] <= '0;
    end else begin
      state <= state_n;
      if (res_ready_i) res_valid_o <= 1'b0;
      if (accept && psum_last_i) begin
        res_o       <= res_n;
        res_valid_o <= 1'b1;
        beat_cnt    <= '0;
        for (int i = 0; i < OUTPUT_NUM; i++) acc[i] <= '0;
      end else if (accept) begin
        for (int i = 0; i < OUTPUT_NUM; i++) acc[i] <= sum[i];
        if (beat_cnt != CW'(MAX_ACC)) beat_cnt <= beat_cnt + CW'(1);
        if (beat_cnt == CW'(MAX_ACC - 1)) err_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum: randomized self-checking bench for psum_accum against a longint group-sum model
module tb_psum_accum;
  import rv_acc_pkg::*;
  localparam int N  = 9;
  localparam int MA = 64;
  localparam int W  = N * DW;
  typedef struct {
    logic [W-1:0] psum;
    logic         last;
    fx_t          bias;
    logic         relu;
  } beat_t;
  logic clk = 0, rst_n = 0, psum_valid = 0, psum_last = 0, relu_en = 0, res_ready = 1;
  logic psum_ready, res_valid, err;
  logic [W-1:0] psum = '0, res;
  fx_t bias = '0;
  always #5 clk = ~clk;
  psum_accum #(.OUTPUT_NUM(N), .MAX_ACC(MA)) dut (
    .clk(clk), .rst_n(rst_n), .psum_i(psum), .psum_valid_i(psum_valid), .psum_last_i(psum_last),
    .psum_ready_o(psum_ready), .bias_i(bias), .relu_en_i(relu_en), .res_o(res),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .err_o(err)
  );
  int total = 0, bad = 0;
  int last_acc_cyc = 0;
  bit stall = 0;
  beat_t beat_q[$];
  logic [W-1:0] exp_q[$], got_q[$];
  int got_cyc[$];
  longint m_acc [N];

  function automatic logic [W-1:0] rnd_vec(input int span);
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'($urandom_range(0, 2 * span) - span);
    return v;
  endfunction

  task automatic push_beat(input logic [W-1:0] v, input logic last, input fx_t b, input logic relu);
    longint r;
    logic [W-1:0] e;
    beat_q.push_back('{v, last, b, relu});
    for (int k = 0; k < N; k++) m_acc[k] += longint'(signed'(v[k*DW +: DW]));
    if (last) begin
      for (int k = 0; k < N; k++) begin
        r = m_acc[k] + longint'(b);
        if (relu && r < 0) r = 0;
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
        e[k*DW +: DW] = r[31:0];
        m_acc[k] = 0;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic run(input int max_cyc, input int n_res);
    int cyc = 0;
    got_q.delete();
    got_cyc.delete();
    while ((beat_q.size() > 0 || got_q.size() < n_res) && cyc < max_cyc) begin
      if (beat_q.size() > 0) begin
        psum = beat_q[0].psum;
        psum_last = beat_q[0].last;
        bias = beat_q[0].bias;
        relu_en = beat_q[0].relu;
        psum_valid = !stall || $urandom_range(0, 3) != 0;
      end else psum_valid = 0;
      res_ready = !stall || $urandom_range(0, 1) == 1;
      @(negedge clk);
      if (res_valid && res_ready) begin
        got_q.push_back(res);
        got_cyc.push_back(cyc);
      end
      if (psum_valid && psum_ready) begin
        void'(beat_q.pop_front());
        last_acc_cyc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    psum_valid = 0;
    res_ready = 1;
    beat_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 0;
    psum_valid = 0;
    res_ready = 1;
    for (int k = 0; k < N; k++) m_acc[k] = 0;
    repeat (2) @(posedge clk); #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
    total++; if (res !== '0) begin bad++; $display("FAIL reset_res: got %h expected 0", res); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", err); end
    total++; if (psum_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", psum_ready); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_three_beat();
    logic [W-1:0] v, g;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'((k + 1) * 256);
    for (int i = 0; i < 3; i++) push_beat(v, i == 2, 32'sd256, 1'b0);
    run(200, 1);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL three_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL three_res[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > 0) g = got_q[0]; else g = '0;
    for (int k = 0; k < N; k++) begin
      total++; if (g[k*DW +: DW] !== DW'((3 * k + 4) * 256)) begin bad++; $display("FAIL three_lane[%0d]: got %h expected %h", k, g[k*DW +: DW], DW'((3 * k + 4) * 256)); end
    end
    if (!stall) begin
      total++;
      if (got_cyc.size() == 0 || got_cyc[0] - last_acc_cyc != 1) begin
        bad++; $display("FAIL three_latency: got %0d expected 1", got_cyc.size() > 0 ? got_cyc[0] - last_acc_cyc : -1);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_relu();
    logic [W-1:0] v, g0, g1;
    v = rnd_vec(4096);
    v[31:0] = 32'hFFFFFE00;
    push_beat(v, 1'b1, '0, 1'b1);
    push_beat(v, 1'b1, '0, 1'b0);
    for (int i = 0; i < 4; i++) push_beat(rnd_vec(100000), 1'b1, fx_t'($urandom_range(0, 4096) - 2048), 1'($urandom_range(0, 1)));
    run(300, 6);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL relu_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL relu_res[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    g0 = got_q.size() > 0 ? got_q[0] : '1;
    g1 = got_q.size() > 1 ? got_q[1] : '0;
    total++; if (g0[31:0] !== 32'h0) begin bad++; $display("FAIL relu_on_lane0: got %h expected 00000000", g0[31:0]); end
    total++; if (g1[31:0] !== 32'hFFFFFE00) begin bad++; $display("FAIL relu_off_lane0: got %h expected fffffe00", g1[31:0]); end
    exp_q.delete();
  endtask

  task automatic test_saturate();
    logic [W-1:0] vp, vn, g0, g1;
    for (int k = 0; k < N; k++) begin
      vp[k*DW +: DW] = 32'h7FFFFF00;
      vn[k*DW +: DW] = 32'h80000000;
    end
    for (int i = 0; i < 4; i++) push_beat(vp, i == 3, '0, 1'b0);
    for (int i = 0; i < 4; i++) push_beat(vn, i == 3, '0, 1'b0);
    run(300, 2);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL sat_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL sat_res[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    g0 = got_q.size() > 0 ? got_q[0] : '0;
    g1 = got_q.size() > 1 ? got_q[1] : '0;
    total++; if (g0[W-1 -: DW] !== 32'h7FFFFFFF) begin bad++; $display("FAIL sat_pos: got %h expected 7fffffff", g0[W-1 -: DW]); end
    total++; if (g1[W-1 -: DW] !== 32'h80000000) begin bad++; $display("FAIL sat_neg: got %h expected 80000000", g1[W-1 -: DW]); end
    exp_q.delete();
  endtask

  task automatic test_hold();
    logic [W-1:0] held;
    fx_t b;
    b = fx_t'($urandom_range(0, 8192) - 4096);
    push_beat(rnd_vec(50000), 1'b1, b, 1'b0);
    push_beat(rnd_vec(50000), 1'b0, b, 1'b0);
    push_beat(rnd_vec(50000), 1'b1, b, 1'b0);
    held = exp_q[0];
    psum = beat_q[0].psum;
    psum_last = 1;
    bias = b;
    relu_en = 0;
    psum_valid = 1;
    res_ready = 0;
    @(negedge clk);
    total++; if (psum_ready !== 1'b1) begin bad++; $display("FAIL hold_first_ready: got %b expected 1", psum_ready); end
    @(posedge clk); #1;
    void'(beat_q.pop_front());
    psum = beat_q[0].psum;
    psum_last = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (psum_ready !== 1'b0 || res_valid !== 1'b1 || res !== held) begin
        bad++; $display("FAIL hold_cycle[%0d]: got ready=%b valid=%b res=%h expected ready=0 valid=1 res=%h", i, psum_ready, res_valid, res, held);
      end
      @(posedge clk); #1;
    end
    run(300, 2);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL hold_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL hold_res[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v;
    fx_t b;
    b = fx_t'($urandom_range(0, 2048));
    for (int n = 1; n <= 8; n++) begin
      for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(n * 256);
      push_beat(v, 1'b1, b, 1'b0);
    end
    run(300, 8);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_res[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    if (!stall) begin
      total++;
      if (got_cyc.size() != 8 || got_cyc[7] - got_cyc[0] != 7) begin
        bad++; $display("FAIL b2b_rate: got %0d results spanning %0d cycles expected 8 spanning 7", got_cyc.size(), got_cyc.size() > 0 ? got_cyc[got_cyc.size()-1] - got_cyc[0] : -1);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int len;
    fx_t b;
    logic relu;
    for (int g = 0; g < 6; g++) begin
      len = $urandom_range(1, 6);
      b = fx_t'($urandom);
      relu = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) push_beat(rnd_vec(1 << 30), i == len - 1, b, relu);
    end
    run(600, 6);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_res[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_overflow();
    psum_last = 0;
    res_ready = 1;
    for (int i = 0; i <= MA; i++) begin
      psum = rnd_vec(1000);
      psum_valid = 1;
      @(posedge clk); #1;
      if (i == MA - 2) begin
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b expected 0 after %0d beats", err, i + 1); end
      end
      if (i == MA - 1) begin
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b expected 1 after %0d beats", err, i + 1); end
      end
    end
    psum_valid = 0;
    repeat (3) @(posedge clk); #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b expected 1", err); end
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ovf_reset_err: got %b expected 0", err); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL ovf_reset_valid: got %b expected 0", res_valid); end
    for (int k = 0; k < N; k++) m_acc[k] = 0;
    push_beat(rnd_vec(50000), 1'b0, fx_t'(32'sd512), 1'b0);
    push_beat(rnd_vec(50000), 1'b1, fx_t'(32'sd512), 1'b0);
    run(100, 1);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ovf_after_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_after_res[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    for (int s = 0; s < 2; s++) begin
      stall = s[0];
      test_three_beat();
      test_relu();
      test_saturate();
      test_hold();
      test_back_to_back();
      test_random();
    end
    stall = 0;
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
